// File: rtl/parser_collector.sv
// parser_collector: merges per-parser token streams back into slice input order
module parser_collector #(
    parameter int NUM_PARSER  = 6,
    parameter int DATA_W      = 144,
    parameter int ORDER_DEPTH = 16,
    parameter int AF_MARGIN   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PARSER-1:0]        grant_in,
    input  logic                         grant_we,
    input  logic [NUM_PARSER-1:0]        par_valid,
    input  logic [NUM_PARSER-1:0]        par_last,
    input  logic [NUM_PARSER*DATA_W-1:0] par_data,
    output logic [NUM_PARSER-1:0]        par_ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         valid_out,
    output logic                         last_out,
    input  logic                         ready_in,
    output logic                         order_afull,
    output logic                         order_empty,
    output logic [1:0]                   err_flags,
    output logic [15:0]                  slice_cnt
);
    localparam int AW = $clog2(ORDER_DEPTH);
    localparam int CW = $clog2(ORDER_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(ORDER_DEPTH);
    localparam logic [CW-1:0] AF_CNT = CW'(ORDER_DEPTH - AF_MARGIN);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [NUM_PARSER-1:0] order_mem [ORDER_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [NUM_PARSER-1:0] cur_sel;
    logic                  one_hot, push, pop, run, hs_last;

    assign run = state == RUN;
    assign one_hot = grant_in != '0 && (grant_in & (grant_in - NUM_PARSER'(1))) == '0;
    assign order_empty = count == '0;
    assign order_afull = count >= AF_CNT;
    assign hs_last = valid_out && ready_in && last_out;
    assign pop = !order_empty && (!run || hs_last);
    assign push = grant_we && one_hot && (count != FULL_CNT || pop);
    assign valid_out = run && |(par_valid & cur_sel);
    assign last_out = run && |(par_last & cur_sel);
    assign par_ready = (run && ready_in) ? cur_sel : '0;

    // select the current parser's beat; cur_sel is one-hot so OR-ing is a mux
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_PARSER; i++)
            data_out = data_out | (cur_sel[i] ? par_data[i*DATA_W +: DATA_W] : '0);
    end

    // leave RUN only when a slice ends with nothing queued behind it
    always_comb begin
        state_nx = state;
        if (!run && !order_empty)
            state_nx = RUN;
        else if (run && hs_last && order_empty)
            state_nx = IDLE;
    end

    // state register and the parser currently being drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_sel <= '0;
        end else begin
            state <= state_nx;
            if (pop)
                cur_sel <= order_mem[rd_ptr];
        end
    end

    // order storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push)
            order_mem[wr_ptr] <= grant_in;
    end

    // order FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push != pop)
                count <= push ? count + CW'(1) : count - CW'(1);
        end
    end

    // sticky drop flags and completed-slice counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flags <= '0;
            slice_cnt <= '0;
        end else begin
            if (grant_we && one_hot && !push)
                err_flags[0] <= 1'b1;
            if (grant_we && !one_hot)
                err_flags[1] <= 1'b1;
            if (hs_last)
                slice_cnt <= slice_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_parser_collector.sv
// tb_parser_collector: random ordered merge against a queue model plus directed corner cases
module tb_parser_collector;
    localparam int NP    = 6;
    localparam int DW    = 144;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    grant_in, par_valid, par_last, par_ready;
    logic             grant_we, ready_in, valid_out, last_out, order_afull, order_empty;
    logic [NP*DW-1:0] par_data;
    logic [DW-1:0]    data_out;
    logic [1:0]       err_flags;
    logic [15:0]      slice_cnt;
    int               n_chk = 0;
    int               n_fail = 0;

    typedef struct packed {
        logic [2:0]    p;
        logic          last;
        logic [DW-1:0] d;
    } beat_t;

    beat_t exp_q[$];
    beat_t pq[NP][$];

    parser_collector #(
        .NUM_PARSER(NP), .DATA_W(DW), .ORDER_DEPTH(DEPTH), .AF_MARGIN(AFM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .grant_in(grant_in), .grant_we(grant_we),
        .par_valid(par_valid), .par_last(par_last), .par_data(par_data),
        .par_ready(par_ready), .data_out(data_out), .valid_out(valid_out),
        .last_out(last_out), .ready_in(ready_in), .order_afull(order_afull),
        .order_empty(order_empty), .err_flags(err_flags), .slice_cnt(slice_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [DW-1:0] enc(input int p);
        return DW'(32'hC0DE_0000 + p);
    endfunction

    task automatic idle_inputs();
        grant_in  = '0;
        grant_we  = 1'b0;
        par_valid = '0;
        par_last  = '0;
        par_data  = '0;
        ready_in  = 1'b0;
    endtask

    task automatic set_all_enc();
        for (int i = 0; i < NP; i++)
            par_data[i*DW +: DW] = enc(i);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int            p, len, ngr, slices;
        beat_t         b;
        logic [NP-1:0] allowed, acc, hold;
        int            q[$];

        // reset values
        do_reset();
        settle();
        check("rst_err", err_flags, 0);
        check("rst_slice_cnt", slice_cnt, 0);
        check("rst_empty", order_empty, 1);
        check("rst_afull", order_afull, 0);
        check("rst_valid", valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_par_ready", par_ready, 0);

        // back-to-back one-beat slices: no bubble, 2-cycle start latency
        grant_we = 1'b1;
        grant_in = 6'b000001;
        settle();
        check("b2b_c0_valid", valid_out, 0);
        tick();
        grant_in = 6'b000010;
        set_all_enc();
        par_valid = 6'b000011;
        par_last = 6'b000011;
        ready_in = 1'b1;
        settle();
        check("b2b_c1_valid", valid_out, 0);
        tick();
        grant_we = 1'b0;
        settle();
        check("b2b_a_valid", valid_out, 1);
        check("b2b_a_data", data_out, enc(0));
        check("b2b_a_last", last_out, 1);
        check("b2b_a_ready", par_ready, 6'b000001);
        tick();
        par_valid = 6'b000010;
        settle();
        check("b2b_b_valid", valid_out, 1);
        check("b2b_b_data", data_out, enc(1));
        check("b2b_b_ready", par_ready, 6'b000010);
        check("b2b_b_empty", order_empty, 1);
        tick();
        par_valid = '0;
        settle();
        check("b2b_done_valid", valid_out, 0);
        check("b2b_slice_cnt", slice_cnt, 2);

        // random ordered merge with random valid gaps and backpressure
        do_reset();
        slices = 0;
        ngr = 0;
        hold = '0;
        for (int cyc = 0; cyc < 5000 && (ngr < 60 || exp_q.size() > 0); cyc++) begin
            grant_we = 1'b0;
            grant_in = '0;
            if (ngr < 60 && !order_afull && $urandom_range(0, 2) == 0) begin
                p = $urandom_range(0, NP - 1);
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b.p = 3'(p);
                    b.last = (k == len - 1);
                    b.d = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
                    pq[p].push_back(b);
                    exp_q.push_back(b);
                end
                grant_we = 1'b1;
                grant_in = NP'(1) << p;
                ngr++;
            end
            for (int i = 0; i < NP; i++) begin
                par_valid[i] = hold[i] || (pq[i].size() > 0 && $urandom_range(0, 3) != 0);
                par_last[i] = pq[i].size() > 0 ? pq[i][0].last : 1'b0;
                par_data[i*DW +: DW] = pq[i].size() > 0 ? pq[i][0].d : DW'($urandom);
            end
            ready_in = $urandom_range(0, 3) != 0;
            settle();
            allowed = (exp_q.size() > 0 && ready_in) ? NP'(1) << exp_q[0].p : '0;
            check("par_ready_mask", par_ready & ~allowed, 0);
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    check("beat_data", data_out, exp_q[0].d);
                    check("beat_last", last_out, exp_q[0].last);
                    check("beat_src_hs", par_valid[exp_q[0].p] & par_ready[exp_q[0].p], 1);
                    if (exp_q[0].last)
                        slices++;
                    void'(exp_q.pop_front());
                end
            end
            acc = par_valid & par_ready;
            tick();
            for (int i = 0; i < NP; i++) begin
                if (acc[i])
                    void'(pq[i].pop_front());
                hold[i] = par_valid[i] && !acc[i];
            end
        end
        idle_inputs();
        settle();
        check("rand_drain", exp_q.size(), 0);
        check("rand_slice_cnt", slice_cnt, slices);
        check("rand_err", err_flags, 0);
        check("rand_empty", order_empty, 1);

        // reset in the middle of a 4-beat slice (bad grant first so err_flags is non-zero)
        grant_we = 1'b1;
        grant_in = 6'b000011;
        tick();
        grant_in = 6'b000100;
        tick();
        grant_we = 1'b0;
        grant_in = '0;
        tick();
        set_all_enc();
        ready_in = 1'b1;
        par_valid = 6'b000100;
        settle();
        check("rm_pre_err", err_flags, 2'b10);
        check("rm_beat0_valid", valid_out, 1);
        tick();
        settle();
        check("rm_beat1_ready", par_ready, 6'b000100);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("rm_valid", valid_out, 0);
        check("rm_par_ready", par_ready, 0);
        check("rm_empty", order_empty, 1);
        check("rm_slice_cnt", slice_cnt, 0);
        check("rm_err", err_flags, 0);

        // ignored and malformed grants
        do_reset();
        grant_in = 6'h3F;
        tick();
        settle();
        check("bg_we0_err", err_flags, 0);
        check("bg_we0_empty", order_empty, 1);
        grant_we = 1'b1;
        grant_in = 6'b000011;
        tick();
        grant_in = 6'b000000;
        tick();
        grant_we = 1'b0;
        settle();
        check("bg_err", err_flags, 2'b10);
        check("bg_empty", order_empty, 1);
        check("bg_afull", order_afull, 0);

        // fill, afull threshold, overflow drop, push with pop at full, then drain in order
        do_reset();
        set_all_enc();
        grant_we = 1'b1;
        grant_in = 6'b000001;
        q = {0};
        tick();
        grant_we = 1'b0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            grant_we = 1'b1;
            grant_in = NP'(1) << (k % NP);
            q.push_back(k % NP);
            tick();
            settle();
            if (k == 13)
                check("full_afull_13", order_afull, 0);
            if (k == 14)
                check("full_afull_14", order_afull, 1);
            if (k == 16)
                check("full_err_16", err_flags, 0);
        end
        grant_in = NP'(1) << 5;
        tick();
        grant_we = 1'b0;
        settle();
        check("full_drop_err", err_flags, 2'b01);
        check("full_stall_valid", valid_out, 0);
        check("full_stall_ready", par_ready, 0);
        par_valid = '1;
        par_last = '1;
        ready_in = 1'b1;
        grant_we = 1'b1;
        grant_in = NP'(1) << 3;
        q.push_back(3);
        for (int i = 0; i < q.size(); i++) begin
            settle();
            check("drain_valid", valid_out, 1);
            check("drain_data", data_out, enc(q[i]));
            check("drain_ready", par_ready, NP'(1) << q[i]);
            tick();
            grant_we = 1'b0;
            if (i == 0) begin
                check("full_pushpop_afull", order_afull, 1);
                check("full_pushpop_err", err_flags, 2'b01);
            end
        end
        settle();
        check("drain_done_valid", valid_out, 0);
        check("drain_done_empty", order_empty, 1);
        check("drain_slice_cnt", slice_cnt, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
